// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: FSM states, protocol bytes
// and the held-key table (code, E0 flag, bit index).
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;

  localparam logic [7:0] KEY_W_CODE     = 8'h1D;
  localparam logic [7:0] KEY_A_CODE     = 8'h1C;
  localparam logic [7:0] KEY_S_CODE     = 8'h1B;
  localparam logic [7:0] KEY_D_CODE     = 8'h23;
  localparam logic [7:0] KEY_UP_CODE    = 8'h75;
  localparam logic [7:0] KEY_LEFT_CODE  = 8'h6B;
  localparam logic [7:0] KEY_DOWN_CODE  = 8'h72;
  localparam logic [7:0] KEY_RIGHT_CODE = 8'h74;

  localparam logic [2:0] KEY_W_IDX     = 3'd0;
  localparam logic [2:0] KEY_A_IDX     = 3'd1;
  localparam logic [2:0] KEY_S_IDX     = 3'd2;
  localparam logic [2:0] KEY_D_IDX     = 3'd3;
  localparam logic [2:0] KEY_UP_IDX    = 3'd4;
  localparam logic [2:0] KEY_LEFT_IDX  = 3'd5;
  localparam logic [2:0] KEY_DOWN_IDX  = 3'd6;
  localparam logic [2:0] KEY_RIGHT_IDX = 3'd7;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup from (scan code, E0 flag) to held-key bit index.
// The E0 flag must match exactly: keypad 75 and arrow E0 75 are different keys.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [2:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = 3'd0;
    if (!ext) begin
      case (code)
        KEY_W_CODE: begin hit = 1'b1; index = KEY_W_IDX; end
        KEY_A_CODE: begin hit = 1'b1; index = KEY_A_IDX; end
        KEY_S_CODE: begin hit = 1'b1; index = KEY_S_IDX; end
        KEY_D_CODE: begin hit = 1'b1; index = KEY_D_IDX; end
        default:    ;
      endcase
    end else begin
      case (code)
        KEY_UP_CODE:    begin hit = 1'b1; index = KEY_UP_IDX;    end
        KEY_LEFT_CODE:  begin hit = 1'b1; index = KEY_LEFT_IDX;  end
        KEY_DOWN_CODE:  begin hit = 1'b1; index = KEY_DOWN_IDX;  end
        KEY_RIGHT_CODE: begin hit = 1'b1; index = KEY_RIGHT_IDX; end
        default:        ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 Set-2 byte sequences (make, E0 make, F0 break, E0 F0 break) into key events
// and a held-key vector. Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeats of held keys.
//
// state        | meaning
// ST_IDLE      | no partial sequence; next byte starts a new one
// ST_GOT_E0    | E0 received, waiting for code or F0
// ST_GOT_F0    | F0 received, waiting for break code
// ST_GOT_E0F0  | E0 F0 received, waiting for extended break code
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TOUT_W         = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic [7:0] held,
  output logic       kbd_error
);

  ps2_state_t        state;
  logic [TOUT_W-1:0] tout;
  logic              lookup_ext;
  logic              map_hit;
  logic [2:0]        map_idx;
  logic              tout_done;
  logic              suppress;

  assign lookup_ext = (state == ST_GOT_E0) || (state == ST_GOT_E0F0);
  assign tout_done  = (tout == TOUT_W'(TIMEOUT_CYCLES - 1));

  ps2_key_map u_key_map (
    .code  (byte_in),
    .ext   (lookup_ext),
    .hit   (map_hit),
    .index (map_idx)
  );

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = map_hit && held[map_idx];
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tout        <= '0;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      held        <= 8'h00;
      kbd_error   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      kbd_error <= 1'b0;

      if (byte_err) begin
        state     <= ST_IDLE;
        tout      <= '0;
        kbd_error <= 1'b1;
      end else if (byte_valid) begin
        tout <= '0;
        case (state)
          ST_IDLE, ST_GOT_E0: begin
            if (byte_in == PS2_PFX_BRK) begin
              state <= (state == ST_IDLE) ? ST_GOT_F0 : ST_GOT_E0F0;
            end else if (byte_in == PS2_PFX_EXT) begin
              state <= ST_GOT_E0;
            end else if ((state == ST_IDLE) && (byte_in == PS2_BAT_OK)) begin
              state <= ST_IDLE;
            end else if ((state == ST_IDLE) &&
                         ((byte_in == PS2_ERR0) || (byte_in == PS2_ERR1))) begin
              kbd_error <= 1'b1;
              held      <= 8'h00;
            end else begin
              state <= ST_IDLE;
              if (!suppress) begin
                key_valid   <= 1'b1;
                key_code    <= byte_in;
                key_ext     <= lookup_ext;
                key_release <= 1'b0;
              end
              if (map_hit) held[map_idx] <= 1'b1;
            end
          end
          ST_GOT_F0, ST_GOT_E0F0: begin
            state <= ST_IDLE;
            if (is_prefix(byte_in)) begin
              kbd_error <= 1'b1;
            end else begin
              key_valid   <= 1'b1;
              key_code    <= byte_in;
              key_ext     <= lookup_ext;
              key_release <= 1'b1;
              if (map_hit) held[map_idx] <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // A byte arriving on the expiry cycle is handled above, so it always wins.
        if (tout_done) begin
          state     <= ST_IDLE;
          tout      <= '0;
          kbd_error <= 1'b1;
        end else begin
          tout <= tout + 1'b1;
        end
      end else begin
        tout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: sequence-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized byte traffic.
module tb_ps2_scancode_decoder;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_err = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic [7:0] held;
  logic       kbd_error;

  int vectors = 0;
  int miscompares = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .TOUT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_err    (byte_err),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .held        (held),
    .kbd_error   (kbd_error)
  );

  always #5 clk = ~clk;

`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  // Reference: held-key table as plain arrays.
  logic [7:0] tbl_code [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
  bit         tbl_ext  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  // Model: what has been seen so far of the current sequence.
  bit         seen_e0, seen_f0;
  int         idle_wait;
  logic [7:0] m_held, m_code;
  bit         m_ext, m_rel, m_kv, m_err;
  int         kv_count;

  function automatic int lookup(input logic [7:0] c, input bit e);
    for (int i = 0; i < 8; i++)
      if (tbl_code[i] == c && tbl_ext[i] == e) return i;
    return -1;
  endfunction

  task automatic emit(input logic [7:0] c, input bit e, input bit rel);
    int idx;
    idx = lookup(c, e);
    if (!rel && FILTER && idx >= 0 && m_held[idx]) begin
    end else begin
      m_kv = 1; m_code = c; m_ext = e; m_rel = rel;
    end
    if (idx >= 0) m_held[idx] = !rel;
  endtask

  task automatic model(input bit r, input bit v, input bit e, input logic [7:0] b);
    m_kv = 0; m_err = 0;
    if (r) begin
      seen_e0 = 0; seen_f0 = 0; idle_wait = 0;
      m_held = 0; m_code = 0; m_ext = 0; m_rel = 0;
    end else if (e) begin
      seen_e0 = 0; seen_f0 = 0; idle_wait = 0; m_err = 1;
    end else if (v) begin
      idle_wait = 0;
      if (seen_f0) begin
        if (b == 8'hE0 || b == 8'hF0) m_err = 1;
        else emit(b, seen_e0, 1);
        seen_e0 = 0; seen_f0 = 0;
      end else if (b == 8'hF0) begin
        seen_f0 = 1;
      end else if (b == 8'hE0) begin
        seen_e0 = 1;
      end else if (!seen_e0 && b == 8'hAA) begin
      end else if (!seen_e0 && (b == 8'h00 || b == 8'hFF)) begin
        m_err = 1; m_held = 0;
      end else begin
        emit(b, seen_e0, 0);
        seen_e0 = 0;
      end
    end else if (seen_e0 || seen_f0) begin
      if (idle_wait == T - 1) begin
        m_err = 1; seen_e0 = 0; seen_f0 = 0; idle_wait = 0;
      end else begin
        idle_wait++;
      end
    end else begin
      idle_wait = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit e, input logic [7:0] b);
    @(negedge clk);
    reset = r; byte_valid = v; byte_err = e; byte_in = b;
    model(r, v, e, b);
    @(posedge clk);
    #1;
    vectors++;
    if (key_valid) kv_count++;
    if (key_valid !== m_kv || kbd_error !== m_err || held !== m_held ||
        key_code !== m_code || key_ext !== m_ext || key_release !== m_rel) begin
      miscompares++;
      $display("FAIL cycle t=%0t in r=%0b v=%0b e=%0b b=%h: got kv=%0b err=%0b held=%h code=%h ext=%0b rel=%0b, want kv=%0b err=%0b held=%h code=%h ext=%0b rel=%0b",
               $time, r, v, e, b, key_valid, kbd_error, held, key_code, key_ext, key_release,
               m_kv, m_err, m_held, m_code, m_ext, m_rel);
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, 0, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    kv_count = 0;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check_lit("reset_held", held, 8'h00);
    check_lit("reset_outs", {4'h0, key_valid, key_ext, key_release, kbd_error}, 8'h00);
    idle(2);

    send(8'h1C);
    check_lit("make_a_kv", {7'h0, key_valid}, 8'h01);
    check_lit("make_a_code", key_code, 8'h1C);
    check_lit("make_a_flags", {6'h0, key_ext, key_release}, 8'h00);
    check_lit("make_a_held", held, 8'h02);
    send(8'hF0); send(8'h1C);
    check_lit("brk_a_rel", {6'h0, key_valid, key_release}, 8'h03);
    check_lit("brk_a_held", held, 8'h00);

    send(8'hE0); send(8'h75);
    check_lit("up_make", {5'h0, key_valid, key_ext, key_release}, 8'h06);
    check_lit("up_held", held, 8'h10);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_lit("up_brk", {5'h0, key_valid, key_ext, key_release}, 8'h07);
    check_lit("up_held_clr", held, 8'h00);
    send(8'h75);
    check_lit("kp8_held", held, 8'h00);

    send(8'hE0);
    idle(T - 1);
    check_lit("tout_not_yet", {7'h0, kbd_error}, 8'h00);
    idle(1);
    check_lit("tout_err", {7'h0, kbd_error}, 8'h01);
    idle(1);
    check_lit("tout_once", {7'h0, kbd_error}, 8'h00);
    send(8'h1D);
    check_lit("after_tout_w", {6'h0, key_valid, key_ext}, 8'h02);
    check_lit("after_tout_held", held, 8'h01);

    send(8'hE0);
    idle(T - 1);
    send(8'h6B);
    check_lit("expiry_byte_wins", {5'h0, key_valid, key_ext, kbd_error}, 8'h06);
    check_lit("expiry_held", held, 8'h21);

    step(0, 1, 1, 8'hF0);
    check_lit("byte_err", {6'h0, key_valid, kbd_error}, 8'h01);
    send(8'h23);
    check_lit("after_err_d", {7'h0, held[3]}, 8'h01);

    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
    check_lit("wasd_held", held & 8'h0F, 8'h0F);
    send(8'hFF);
    check_lit("ff_err", {7'h0, kbd_error}, 8'h01);
    check_lit("ff_held", held, 8'h00);
    send(8'hAA);
    check_lit("bat_no_event", {6'h0, key_valid, kbd_error}, 8'h00);

    kv_count = 0;
    send(8'h1D); send(8'h1D); send(8'h1D);
    check_lit("typematic_pulses", 8'(kv_count), FILTER ? 8'd1 : 8'd3);

    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      int sel;
      if ($urandom_range(0, 79) == 0) begin
        send(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0);
        idle($urandom_range(T - 3, T + 2));
        continue;
      end
      sel = $urandom_range(0, 15);
      if (sel < 8) b = tbl_code[sel];
      else if (sel < 10) b = 8'hE0;
      else if (sel < 12) b = 8'hF0;
      else if (sel == 12) b = 8'hAA;
      else if (sel == 13) b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF) : 8'h75;
      else b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes raw PS/2 bytes from the keyboard receiver stage and assembles Set-2 scan-code sequences into single key events.
- Sequences handled: plain make, E0 extended, F0 break, E0 F0 extended break.
- Maintains an 8-bit held-key vector (WASD plus arrow keys) that the game control logic samples directly.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles a prefix state may wait for its next byte before abandoning the sequence.
- TOUT_W, 17, width of the timeout counter; must satisfy 2^TOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- byte_in  in  8  received scan-code byte, LSB-first data already reassembled.
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle.
- byte_err  in  1  one-cycle strobe; the receiver saw a parity or stop-bit error on the current frame.
- key_valid  out  1  one-cycle strobe; a complete key event is present.
- key_code  out  8  final (non-prefix) scan code of the event.
- key_ext  out  1  event was E0-prefixed.
- key_release  out  1  event was a break (F0-prefixed).
- held  out  8  held keys: [0]W 1D, [1]A 1C, [2]S 1B, [3]D 23, [4]Up E0 75, [5]Left E0 6B, [6]Down E0 72, [7]Right E0 74.
- kbd_error  out  1  one-cycle strobe: keyboard error code (00/FF), byte_err, or timeout.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, and the timeout counter is cleared. A reset mid-sequence discards the partial sequence.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- From IDLE:
  - byte E0 -> GOT_E0.
  - byte F0 -> GOT_F0.
  - byte AA (BAT pass) -> ignored, stay in IDLE.
  - bytes 00/FF -> kbd_error, clear held, stay in IDLE.
  - any other byte -> make event with ext=0.
- From GOT_E0:
  - byte F0 -> GOT_E0F0.
  - byte E0 -> stay in GOT_E0.
  - other byte -> make event with ext=1, go to IDLE.
- From GOT_F0: any byte except E0/F0 -> break event with ext=0, go to IDLE. E0 or F0 -> kbd_error, go to IDLE.
- From GOT_E0F0: any byte except E0/F0 -> break event with ext=1, go to IDLE. E0 or F0 -> kbd_error, go to IDLE.
- Event latency: key_valid, key_code, key_ext and key_release are registered and assert on the clock after the byte_valid cycle of the final byte. key_code, key_ext and key_release hold their values until the next event.
- held update: on the same edge as the key_valid assertion, a make sets the mapped bit and a break clears it. Unmapped codes leave held unchanged. A code's ext flag must match its table entry: 75 without E0 (keypad 8) does not map.
- Timeout: the counter runs only in the prefix states and is cleared on every byte_valid. When it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE and kbd_error pulses. If byte_valid coincides with expiry, the byte wins: it is processed in the current state and no error is raised.
- byte_err: the byte is dropped, the FSM goes to IDLE, and kbd_error pulses. byte_err has priority over byte_valid in the same cycle. held is not modified.
- Typematic repeats: with the optional feature out, a repeated make of an already-held key produces key_valid every time.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event whose code maps to a held bit that is already 1 is suppressed (no key_valid). Unmapped codes are never suppressed.
- Undefined: every complete make sequence produces key_valid.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum;
  - the localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - the eight key-code localparams with their held-bit indices.
- Sub-module ps2_key_map: combinational code+ext -> {hit, index[2:0]}. This lookup is reused by later game-input logic.

Test Plan:
- Bytes 1C -> key_valid one cycle after the strobe, with key_code=1C, ext=0, release=0, and held=8'h02. Then F0,1C -> key_valid with release=1, and held=8'h00.
- E0,75 then E0,F0,75 -> first event has ext=1 and held[4]=1; second has ext=1, release=1 and held[4]=0. Plain 75 leaves held at 0.
- E0, then TIMEOUT_CYCLES idle cycles -> kbd_error pulses once and the FSM returns to IDLE. A following 1D -> make event with ext=0 and held[0]=1.
- F0 with byte_err asserted in the same cycle as byte_valid -> kbd_error, no event. A following 23 -> make event with held[3]=1.
- Hold W, A, S, D, then send FF -> kbd_error and held=8'h00. Sending AA in IDLE -> no event.
- Send 1D three times -> three key_valid pulses when the macro is undefined; one pulse when PS2_TYPEMATIC_FILTER_EN is defined.
